// File: rtl/pass_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pass_sequencer
// Purpose  : Sequences NUM_FWD forward passes followed by one backward pass,
//            repeated for a programmable number of iterations. Drives the
//            datapath pass engines with one-hot pass-select strobes.
// Revision : 1.0 - initial release
//
// Parameters
//   NUM_FWD  forward passes per iteration (1..8)
//   ITER_W   width of iteration count / index
//   TMO_W    width of watchdog limit / per-pass cycle counter
//
// Ports
//   clk_i        clock
//   rst_i        synchronous active-high reset (overrides en_i)
//   en_i         global enable; low freezes every register
//   init_i       start request, sampled only in IDLE
//   iters_i      iteration count, latched on accepted init_i (0 acts as 1)
//   pass_end_i   current pass complete
//   abort_i      abandon the sequence
//   tmo_limit_i  watchdog limit in cycles, 0 disables
//   fwd_pass_o   one-hot active forward pass (zero outside FWD)
//   b_pass_o     backward pass active
//   busy_o       in FWD or BWD
//   done_o       single-cycle DONE state
//   iter_o       current iteration index
//   timeout_o    sticky watchdog-expiry flag
//
// Build option
//   PASS_SEQ_TIMEOUT_EN  builds the per-pass watchdog; when undefined the
//                        counter is absent and timeout_o is tied low.
// ============================================================================
module pass_sequencer #(
    parameter int NUM_FWD = 2,
    parameter int ITER_W  = 4,
    parameter int TMO_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               init_i,
    input  logic [ITER_W-1:0]  iters_i,
    input  logic               pass_end_i,
    input  logic               abort_i,
    input  logic [TMO_W-1:0]   tmo_limit_i,
    output logic [NUM_FWD-1:0] fwd_pass_o,
    output logic               b_pass_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [ITER_W-1:0]  iter_o,
    output logic               timeout_o
);

    localparam int c_PIDX_W = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1;
    localparam logic [c_PIDX_W-1:0] c_LAST_PIDX = c_PIDX_W'(NUM_FWD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_BWD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [c_PIDX_W-1:0] r_pass_idx, w_pass_idx_nxt;
    logic [ITER_W-1:0]   r_iter,     w_iter_nxt;
    logic [ITER_W-1:0]   r_count,    w_count_nxt;

    logic w_init_acc;    // init_i accepted this cycle
    logic w_pass_entry;  // a new pass (forward or backward) starts next cycle
    logic w_tmo_fire;    // watchdog ends the current pass
    logic w_tmo_expire;  // watchdog limit reached (qualified below by state)

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_pass_idx <= '0;
            r_iter     <= '0;
            r_count    <= '0;
        end else if (en_i) begin
            r_state    <= w_state_nxt;
            r_pass_idx <= w_pass_idx_nxt;
            r_iter     <= w_iter_nxt;
            r_count    <= w_count_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Priority in FWD/BWD: abort, watchdog, pass_end.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_pass_idx_nxt = r_pass_idx;
        w_iter_nxt     = r_iter;
        w_count_nxt    = r_count;
        w_init_acc     = 1'b0;
        w_pass_entry   = 1'b0;
        w_tmo_fire     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (init_i) begin
                    w_count_nxt    = (iters_i == '0) ? ITER_W'(1) : iters_i;
                    w_iter_nxt     = '0;
                    w_pass_idx_nxt = '0;
                    w_state_nxt    = S_FWD;
                    w_init_acc     = 1'b1;
                    w_pass_entry   = 1'b1;
                end
            end
            S_FWD, S_BWD: begin
                if (abort_i) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tmo_expire) begin
                    w_state_nxt = S_IDLE;
                    w_tmo_fire  = 1'b1;
                end else if (pass_end_i) begin
                    if (r_state == S_FWD) begin
                        w_pass_entry = 1'b1;
                        if (r_pass_idx < c_LAST_PIDX) begin
                            w_pass_idx_nxt = r_pass_idx + c_PIDX_W'(1);
                        end else begin
                            w_state_nxt = S_BWD;
                        end
                    // Count is never 0 once latched, so count-1 cannot wrap.
                    end else if (r_iter < (r_count - ITER_W'(1))) begin
                        w_iter_nxt     = r_iter + ITER_W'(1);
                        w_pass_idx_nxt = '0;
                        w_state_nxt    = S_FWD;
                        w_pass_entry   = 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-pass watchdog
    // ------------------------------------------------------------------
`ifdef PASS_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout;

    assign w_tmo_expire = (tmo_limit_i != '0) &&
                          (r_tmo_cnt == (tmo_limit_i - TMO_W'(1)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else if (en_i) begin
            if (w_pass_entry) begin
                r_tmo_cnt <= '0;
            end else if (((r_state == S_FWD) || (r_state == S_BWD)) &&
                         (r_tmo_cnt != '1)) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end

            if (w_init_acc) begin
                r_timeout <= 1'b0;
            end else if (w_tmo_fire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    logic w_unused_tmo;

    assign w_tmo_expire = 1'b0;
    assign w_unused_tmo = ^{tmo_limit_i, w_init_acc, w_pass_entry, w_tmo_fire};
    assign timeout_o    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    assign fwd_pass_o = (r_state == S_FWD) ? (NUM_FWD'(1) << r_pass_idx) : '0;
    assign b_pass_o   = (r_state == S_BWD);
    assign busy_o     = (r_state == S_FWD) || (r_state == S_BWD);
    assign done_o     = (r_state == S_DONE);
    assign iter_o     = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_pass_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pass_sequencer
// Purpose  : Directed self-checking bench for pass_sequencer. Two instances
//            share stimulus: u_dut2 (NUM_FWD=2) and u_dut1 (NUM_FWD=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pass_sequencer;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic       init_i;
    logic [3:0] iters_i;
    logic       pass_end_i;
    logic       abort_i;
    logic [7:0] tmo_limit_i;

    logic [1:0] fwd2;
    logic       b2, busy2, done2, tmo2;
    logic [3:0] iter2;
    logic [0:0] fwd1;
    logic       b1, busy1, done1, tmo1;
    logic [3:0] iter1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pass_sequencer #(.NUM_FWD(2), .ITER_W(4), .TMO_W(8)) u_dut2 (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .init_i(init_i),
        .iters_i(iters_i), .pass_end_i(pass_end_i), .abort_i(abort_i),
        .tmo_limit_i(tmo_limit_i), .fwd_pass_o(fwd2), .b_pass_o(b2),
        .busy_o(busy2), .done_o(done2), .iter_o(iter2), .timeout_o(tmo2)
    );

    pass_sequencer #(.NUM_FWD(1), .ITER_W(4), .TMO_W(8)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .init_i(init_i),
        .iters_i(iters_i), .pass_end_i(pass_end_i), .abort_i(abort_i),
        .tmo_limit_i(tmo_limit_i), .fwd_pass_o(fwd1), .b_pass_o(b1),
        .busy_o(busy1), .done_o(done1), .iter_o(iter1), .timeout_o(tmo1)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; en_i = 1'b1; init_i = 1'b0; pass_end_i = 1'b0;
        abort_i = 1'b0; iters_i = 4'd0; tmo_limit_i = 8'd0;
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({fwd2, b2, busy2, done2, iter2, tmo2} !== 10'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {fwd2, b2, busy2, done2, iter2, tmo2});
        end
        // Run into FWD with pass_idx=1, then reset while en_i is low.
        iters_i = 4'd1; init_i = 1'b1; step();
        init_i = 1'b0; pass_end_i = 1'b1; step();
        pass_end_i = 1'b0;
        checks++;
        if (fwd2 !== 2'b10) begin
            failures++;
            $display("FAIL reset_pre_fwd got=%b exp=10", fwd2);
        end
        rst_i = 1'b1; en_i = 1'b0; step();
        checks++;
        if ({fwd2, b2, busy2, done2, iter2, tmo2} !== 10'd0) begin
            failures++;
            $display("FAIL reset_midrun got=%b exp=0", {fwd2, b2, busy2, done2, iter2, tmo2});
        end
        rst_i = 1'b0; en_i = 1'b1; step();
        checks++;
        if ({fwd2, busy2, done2} !== 4'd0) begin
            failures++;
            $display("FAIL reset_idle_after got=%b exp=0", {fwd2, busy2, done2});
        end
    endtask

    task automatic test_nominal();
        logic [1:0] e_fwd;
        int k;
        do_reset();
        iters_i = 4'd1;
        for (int c = 0; c < 10; c++) begin
            init_i     = (c == 0);
            pass_end_i = (c == 3) || (c == 5) || (c == 8);
            step();
            k = c + 1;
            e_fwd = (k >= 1 && k <= 3) ? 2'b01 : (k >= 4 && k <= 5) ? 2'b10 : 2'b00;
            checks++;
            if (fwd2 !== e_fwd) begin
                failures++;
                $display("FAIL nominal_fwd cycle=%0d got=%b exp=%b", k, fwd2, e_fwd);
            end
            checks++;
            if (b2 !== (k >= 6 && k <= 8)) begin
                failures++;
                $display("FAIL nominal_bwd cycle=%0d got=%b", k, b2);
            end
            checks++;
            if (done2 !== (k == 9)) begin
                failures++;
                $display("FAIL nominal_done cycle=%0d got=%b", k, done2);
            end
            checks++;
            if (busy2 !== (k >= 1 && k <= 8)) begin
                failures++;
                $display("FAIL nominal_busy cycle=%0d got=%b", k, busy2);
            end
        end
        init_i = 1'b0; pass_end_i = 1'b0;
    endtask

    // Iteration stepping observed on the NUM_FWD=1 instance.
    task automatic test_iterations();
        do_reset();
        iters_i = 4'd3; pass_end_i = 1'b1; init_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            init_i = 1'b0;
            if (k <= 6) begin
                checks++;
                if (iter1 !== 4'((k - 1) / 2)) begin
                    failures++;
                    $display("FAIL iter_index cycle=%0d got=%0d exp=%0d", k, iter1, (k - 1) / 2);
                end
            end
            checks++;
            if (done1 !== (k == 7)) begin
                failures++;
                $display("FAIL iter_done cycle=%0d got=%b exp=%b", k, done1, (k == 7));
            end
        end
        // Count 0 behaves as 1.
        do_reset();
        iters_i = 4'd0; pass_end_i = 1'b1; init_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            init_i = 1'b0;
            checks++;
            if ({busy1, done1} !== {(k == 1 || k == 2), (k == 3)}) begin
                failures++;
                $display("FAIL iter_zero cycle=%0d got=%b%b", k, busy1, done1);
            end
        end
        // Maximum count: 15 iterations, done at cycle 15*2+1.
        do_reset();
        iters_i = 4'd15; pass_end_i = 1'b1; init_i = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            init_i = 1'b0;
            if (k == 30) begin
                checks++;
                if (iter1 !== 4'd14) begin
                    failures++;
                    $display("FAIL iter_max_index got=%0d exp=14", iter1);
                end
            end
            checks++;
            if (done1 !== (k == 31)) begin
                failures++;
                $display("FAIL iter_max_done cycle=%0d got=%b", k, done1);
            end
        end
        pass_end_i = 1'b0;
    endtask

    task automatic test_enable_priority();
        do_reset();
        iters_i = 4'd2; init_i = 1'b1; step();
        init_i = 1'b0; pass_end_i = 1'b1; step(); step();
        checks++;
        if ({b2, iter2} !== {1'b1, 4'd0}) begin
            failures++;
            $display("FAIL en_enter_bwd got=%b/%0d exp=1/0", b2, iter2);
        end
        // Enable low: every input ignored, nothing advances.
        en_i = 1'b0; abort_i = 1'b1; init_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({b2, busy2, iter2} !== {1'b1, 1'b1, 4'd0}) begin
                failures++;
                $display("FAIL en_hold k=%0d got=%b%b/%0d exp=11/0", k, b2, busy2, iter2);
            end
        end
        en_i = 1'b1; abort_i = 1'b0; init_i = 1'b0; step();
        checks++;
        if ({fwd2, iter2} !== {2'b01, 4'd1}) begin
            failures++;
            $display("FAIL en_resume got=%b/%0d exp=01/1", fwd2, iter2);
        end
        // abort wins over pass_end.
        abort_i = 1'b1; step();
        abort_i = 1'b0; pass_end_i = 1'b0;
        checks++;
        if ({fwd2, busy2, done2} !== 4'd0) begin
            failures++;
            $display("FAIL abort_idle got=%b exp=0", {fwd2, busy2, done2});
        end
        step();
        checks++;
        if (done2 !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got=%b exp=0", done2);
        end
        // init while busy must not relatch the count or restart.
        iters_i = 4'd1; init_i = 1'b1; step();
        init_i = 1'b0; pass_end_i = 1'b1; step();
        pass_end_i = 1'b0; init_i = 1'b1; iters_i = 4'd3; step();
        init_i = 1'b0;
        checks++;
        if (fwd2 !== 2'b10) begin
            failures++;
            $display("FAIL init_busy_fwd got=%b exp=10", fwd2);
        end
        pass_end_i = 1'b1; step();
        checks++;
        if (b2 !== 1'b1) begin
            failures++;
            $display("FAIL init_busy_bwd got=%b exp=1", b2);
        end
        step();
        pass_end_i = 1'b0;
        checks++;
        if (done2 !== 1'b1) begin
            failures++;
            $display("FAIL init_busy_done got=%b exp=1", done2);
        end
        step();
        checks++;
        if ({busy2, done2} !== 2'b00) begin
            failures++;
            $display("FAIL done_to_idle got=%b exp=00", {busy2, done2});
        end
    endtask

`ifdef PASS_SEQ_TIMEOUT_EN
    task automatic test_watchdog();
        do_reset();
        tmo_limit_i = 8'd5; iters_i = 4'd1; init_i = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            init_i = 1'b0;
            checks++;
            if ({busy2, tmo2} !== {(k <= 5), (k >= 6)}) begin
                failures++;
                $display("FAIL wdog_expiry cycle=%0d got=%b%b exp=%b%b", k, busy2, tmo2, (k <= 5), (k >= 6));
            end
        end
        init_i = 1'b1; step();
        init_i = 1'b0;
        checks++;
        if ({busy2, tmo2} !== 2'b10) begin
            failures++;
            $display("FAIL wdog_clear got=%b%b exp=10", busy2, tmo2);
        end
        // Counter must restart when pass_idx increments.
        tmo_limit_i = 8'd3; step();
        pass_end_i = 1'b1; step();
        pass_end_i = 1'b0; step(); step();
        checks++;
        if ({fwd2, busy2, tmo2} !== 4'b1010) begin
            failures++;
            $display("FAIL wdog_pass_restart got=%b exp=1010", {fwd2, busy2, tmo2});
        end
        step();
        checks++;
        if ({busy2, tmo2} !== 2'b01) begin
            failures++;
            $display("FAIL wdog_second_expiry got=%b%b exp=01", busy2, tmo2);
        end
    endtask
`endif

    task automatic test_watchdog_disabled();
        do_reset();
        tmo_limit_i = 8'd0; iters_i = 4'd1; init_i = 1'b1; step();
        init_i = 1'b0;
        for (int k = 0; k < 300; k++) begin
            step();
            checks++;
            if ({fwd2, busy2, tmo2} !== 4'b0110) begin
                failures++;
                $display("FAIL wdog_off_hold k=%0d got=%b exp=0110", k, {fwd2, busy2, tmo2});
            end
        end
`ifndef PASS_SEQ_TIMEOUT_EN
        tmo_limit_i = 8'd5;
        for (int k = 0; k < 300; k++) begin
            step();
            checks++;
            if ({fwd2, busy2, tmo2} !== 4'b0110) begin
                failures++;
                $display("FAIL wdog_absent_hold k=%0d got=%b exp=0110", k, {fwd2, busy2, tmo2});
            end
        end
`endif
        abort_i = 1'b1; step();
        abort_i = 1'b0;
        checks++;
        if ({busy2, tmo2} !== 2'b00) begin
            failures++;
            $display("FAIL wdog_off_abort got=%b%b exp=00", busy2, tmo2);
        end
    endtask

    initial begin
        rst_i = 1'b1; en_i = 1'b0; init_i = 1'b0; iters_i = 4'd0;
        pass_end_i = 1'b0; abort_i = 1'b0; tmo_limit_i = 8'd0;
        #2;
        test_reset();
        test_nominal();
        test_iterations();
        test_enable_priority();
`ifdef PASS_SEQ_TIMEOUT_EN
        test_watchdog();
`endif
        test_watchdog_disabled();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pass_sequencer.md
# pass_sequencer

Parametrised successor to the single forward-pass controller. It steps through `NUM_FWD` forward passes and then one backward pass, and repeats that round a programmable number of iterations. Each pass ends on `pass_end_i`, and an optional per-pass watchdog can end it early. The block sits between the top-level control inputs and the datapath pass engines, which it drives with one-hot pass-select strobes.

## Interface
- `NUM_FWD`, default 2: number of forward passes per iteration; legal range 1..8.
- `ITER_W`, default 4: width of the iteration count and iteration index.
- `TMO_W`, default 8: width of the watchdog limit and per-pass cycle counter.

- `clk_i`  in  1  clock; one clock domain.
- `rst_i`  in  1  reset; synchronous, active-high.
- `en_i`  in  1  global enable, driven from top-level `ena`. Low means every register holds.
- `init_i`  in  1  start request; sampled only in IDLE.
- `iters_i`  in  ITER_W  iteration count, latched when `init_i` is accepted; 0 is treated as 1.
- `pass_end_i`  in  1  current pass complete.
- `abort_i`  in  1  abandon the sequence.
- `tmo_limit_i`  in  TMO_W  watchdog limit in cycles; 0 disables the watchdog.
- `fwd_pass_o`  out  NUM_FWD  one-hot active forward pass; all zeros outside FWD.
- `b_pass_o`  out  1  backward pass active.
- `busy_o`  out  1  high in FWD or BWD.
- `done_o`  out  1  high for the single DONE state.
- `iter_o`  out  ITER_W  current iteration index, starting at 0.
- `timeout_o`  out  1  sticky watchdog-expiry flag.

## Operation
- States: IDLE, FWD, BWD, DONE.
- Registers: state, `pass_idx` (clog2(NUM_FWD) bits, minimum 1), `iter`, latched iteration count, `tmo_cnt`, `timeout` flag.
- All outputs are Moore outputs, decoded from registers only. There is no combinational path from any input to any output.
- Reset (`rst_i` high at a clock edge) takes priority over `en_i`. It sets state to IDLE and clears `pass_idx`, `iter`, `tmo_cnt` and `timeout`.
  - After reset every output is 0.
- When `en_i` is low, nothing advances, including the DONE dwell and the watchdog. All inputs are ignored.
- State transitions, evaluated only when `en_i` is high:
  - IDLE: on `init_i`, latch `iters_i`, clear `iter`, `pass_idx` and `timeout`, and go to FWD.
  - FWD: on `pass_end_i`, if `pass_idx` < NUM_FWD-1, increment `pass_idx`; otherwise go to BWD.
  - BWD: on `pass_end_i`, if `iter` < count-1, increment `iter`, clear `pass_idx` and go to FWD; otherwise go to DONE.
  - DONE: go to IDLE unconditionally on the next enabled cycle.
- Priority within FWD/BWD: `abort_i` first, then watchdog expiry, then `pass_end_i`.
  - `abort_i` returns the block to IDLE; `done_o` is not asserted and `timeout` is unchanged.
- Ignored inputs: `init_i` outside IDLE, and `pass_end_i` and `abort_i` in IDLE or DONE.
- `iter` does not wrap, because the latched count bounds it. A count of 2^ITER_W-1 runs exactly that many iterations.

## Timing
- Every transition is visible on the outputs one cycle after the triggering input is sampled.
- Minimum sequence with `NUM_FWD`=N and count K, one cycle per pass:
  - `init_i` accepted at cycle 0.
  - First forward pass begins at cycle 1.
  - DONE is reached at cycle K*(N+1)+1, with `done_o` high for exactly one enabled cycle.
  - The block is back in IDLE one cycle later.
- A `pass_end_i` held high for several cycles advances the sequence once per enabled cycle.

## Configuration
- Macro: `PASS_SEQ_TIMEOUT_EN`.
- When defined:
  - `tmo_cnt` clears on entry to every pass (including each increment of `pass_idx`) and increments each enabled cycle spent in FWD/BWD.
  - If `tmo_limit_i` is non-zero and `tmo_cnt` equals `tmo_limit_i`-1 with no `abort_i`, the block goes to IDLE and sets `timeout`. `timeout` stays set until the next accepted `init_i`.
  - The counter saturates at its maximum value.
- When undefined: no counter is built, `tmo_limit_i` is unused, and `timeout_o` is tied to 0.

## Test plan
- Reset mid-run: reset asserted in FWD with `pass_idx`=1 -> next cycle all outputs 0 and state IDLE; `en_i` low does not block reset.
- Nominal run, N=2, `iters_i`=1: `init_i` at cycle 0, `pass_end_i` pulses at cycles 3, 5 and 8 ->
  - `fwd_pass_o`=01 for cycles 1-3;
  - `fwd_pass_o`=10 for cycles 4-5;
  - `b_pass_o` for cycles 6-8;
  - `done_o` at cycle 9 only.
- Iterations, N=1, `iters_i`=3, `pass_end_i` held high -> `iter_o` steps 0, 0, 1, 1, 2, 2 and `done_o` at cycle 7. Repeat with `iters_i`=0 -> behaves as 1.
- Enable gating and priority:
  - `en_i` low for 4 cycles during BWD -> `b_pass_o` held, nothing advances;
  - `abort_i` and `pass_end_i` together in FWD -> IDLE, no `done_o`;
  - `init_i` during busy -> ignored.
- Watchdog, macro defined, `tmo_limit_i`=5, no `pass_end_i` -> IDLE and `timeout_o`=1 on the 6th cycle after pass entry; the next `init_i` clears it.
- Watchdog disabled: `tmo_limit_i`=0, or macro undefined -> FWD holds for 300 cycles and `timeout_o` stays 0.
